// File: rtl/uart_rx_buffered_if.sv
// CPU-side port bundle of the buffered RS232 receiver (PicoBlaze input-port mux side).
interface uart_rx_buffered_if;
  logic [7:0] rx_data_out;
  logic       read_rx_data_ack;
  logic       rx_data_present;
  logic       rx_buffer_full;
  logic       rx_overrun;
  logic       rx_framing_error;
  logic       clear_errors;

  modport master (
    output read_rx_data_ack, clear_errors,
    input  rx_data_out, rx_data_present, rx_buffer_full, rx_overrun, rx_framing_error
  );

  modport slave (
    input  read_rx_data_ack, clear_errors,
    output rx_data_out, rx_data_present, rx_buffer_full, rx_overrun, rx_framing_error
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// 16x-oversampling 8N1 receiver feeding a first-word-fall-through byte FIFO,
// with sticky overrun and framing-error flags.
module uart_rx_buffered #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rs232_rx,
  uart_rx_buffered_if.slave  bus
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
  localparam int unsigned TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      sample_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            armed;
  logic            mid_start, bit_end;
  logic            stop_ok, stop_bad;
  logic            push_req;

  logic [7:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic            empty, full, do_pop, do_push, ovr_set;
  logic            overrun_q, framing_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rs232_rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (state != IDLE) && (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      tick_cnt <= '0;
    else if (state == IDLE || tick)  tick_cnt <= '0;
    else                             tick_cnt <= tick_cnt + TW'(1);
  end

  assign mid_start = tick && (sample_cnt == 4'd7);
  assign bit_end   = tick && (sample_cnt == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (armed && !rx_s)              state_nxt = START;
      START: if (mid_start)                   state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (bit_end && bit_idx == 3'd7)  state_nxt = STOP;
      STOP:  if (bit_end)                     state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (state == STOP && bit_end) begin
      stop_ok  = rx_s;
      stop_bad = !rx_s;
    end
  end

  // armed drops on a bad stop bit so a held-low line (break) is not
  // mistaken for a fresh start bit; it rearms once the line is seen high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      armed      <= 1'b1;
      push_req   <= 1'b0;
    end else begin
      push_req <= stop_ok;
      case (state)
        IDLE: begin
          sample_cnt <= '0;
          bit_idx    <= '0;
          if (rx_s) armed <= 1'b1;
        end
        START: begin
          if (mid_start)  sample_cnt <= '0;
          else if (tick)  sample_cnt <= sample_cnt + 4'd1;
        end
        DATA: begin
          if (tick) sample_cnt <= sample_cnt + 4'd1;
          if (bit_end) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (tick) sample_cnt <= sample_cnt + 4'd1;
          if (stop_bad) armed <= 1'b0;
        end
        default: sample_cnt <= '0;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_pop  = bus.read_rx_data_ack && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      if (ovr_set)               overrun_q <= 1'b1;
      else if (bus.clear_errors) overrun_q <= 1'b0;
      if (stop_bad)              framing_q <= 1'b1;
      else if (bus.clear_errors) framing_q <= 1'b0;
    end
  end

  assign bus.rx_data_out      = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
  assign bus.rx_data_present  = !empty;
  assign bus.rx_buffer_full   = full;
  assign bus.rx_overrun       = overrun_q;
  assign bus.rx_framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed + randomized bench for uart_rx_buffered; a byte queue models the FIFO
// and two bits model the sticky flags.
module tb_uart_rx_buffered;
  localparam int unsigned CLK_FREQ = 100000000;
  localparam int unsigned BAUD     = 1562500;          // DIV = 4
  localparam int unsigned DIV      = 4;
  localparam int unsigned BIT      = 16 * DIV;
  localparam int unsigned DEPTH    = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rs232_rx;
  always #5 clk = ~clk;

  uart_rx_buffered_if bus ();

  uart_rx_buffered #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .FIFO_AW  (4)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .rs232_rx (rs232_rx),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  byte unsigned exp_q[$];
  bit exp_ovr = 1'b0;
  bit exp_fe  = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_present"}, bus.rx_data_present, exp_q.size() != 0);
    chk({tag, "_full"},    bus.rx_buffer_full,  exp_q.size() == DEPTH);
    chk({tag, "_overrun"}, bus.rx_overrun,      exp_ovr);
    chk({tag, "_framing"}, bus.rx_framing_error, exp_fe);
    if (exp_q.size() != 0) chk({tag, "_head"}, bus.rx_data_out, exp_q[0]);
  endtask

  // Drives one 8N1 frame; ack_off >= 0 pulses ack that many cycles into the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int ack_off);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      rs232_rx = bits[b];
      for (int i = 1; i < BIT; i++) begin
        @(negedge clk);
        if (b == 9) bus.read_rx_data_ack = (i == ack_off);
      end
    end
    @(negedge clk);
    bus.read_rx_data_ack = 1'b0;
    rs232_rx = 1'b1;
    if (stop_bit) begin
      if (ack_off >= 0 && exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      exp_ovr = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    chk({tag, "_pop_present"}, bus.rx_data_present, exp_q.size() != 0);
    if (exp_q.size() != 0) chk({tag, "_pop_data"}, bus.rx_data_out, exp_q[0]);
    bus.read_rx_data_ack = 1'b1;
    @(negedge clk);
    bus.read_rx_data_ack = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},    bus.rx_data_out,      8'h00);
    chk({tag, "_present"}, bus.rx_data_present,  8'h00);
    chk({tag, "_full"},    bus.rx_buffer_full,   8'h00);
    chk({tag, "_overrun"}, bus.rx_overrun,       8'h00);
    chk({tag, "_framing"}, bus.rx_framing_error, 8'h00);
  endtask

  initial begin
    logic [7:0] rb;
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    bus.read_rx_data_ack = 1'b0;
    bus.clear_errors = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // single byte, then pop empties next cycle
    send_frame(8'hA5, 1'b1, -1);
    check_state("t1");
    pop_check("t1");
    check_state("t1_after_pop");

    // fill, overrun, drain in order
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, -1);
    check_state("t2_full");
    send_frame(8'h10, 1'b1, -1);
    check_state("t2_overrun");
    for (int i = 0; i < 16; i++) pop_check("t2_drain");
    check_state("t2_empty");
    pop_check("t2_ack_empty");
    check_state("t2_ack_empty_after");
    clear_pulse();
    check_state("t2_cleared");

    // bad stop bit
    send_frame(8'h3C, 1'b0, -1);
    check_state("t3_ferr");
    clear_pulse();
    check_state("t3_cleared");

    // 4-tick low glitch is rejected
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_state("t4_glitch");
    send_frame(8'h5A, 1'b1, -1);
    check_state("t4_rx");
    pop_check("t4");

    // reset mid-frame with non-zero outputs beforehand
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b0, -1);
    check_state("t5_pre");
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (3 * BIT + BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("t5_reset");
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    rst_n = 1'b1;
    repeat (8 * BIT) @(negedge clk);
    check_state("t5_abandoned");
    send_frame(8'h81, 1'b1, -1);
    check_state("t5_rx");
    pop_check("t5");
    check_state("t5_single");

    // full FIFO, ack coincident with 17th push
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, -1);
    check_state("t6_full");
    rb = 8'($urandom);
    send_frame(rb, 1'b1, 3 + 8 * DIV);
    check_state("t6_swap");
    for (int i = 0; i < 16; i++) pop_check("t6_drain");
    check_state("t6_empty");

    // break: one framing error, no restart until line goes high
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (10 * BIT + 20) @(negedge clk);
    exp_fe = 1'b1;
    check_state("brk_ferr");
    clear_pulse();
    repeat (12 * BIT) @(negedge clk);
    check_state("brk_held");
    rs232_rx = 1'b1;
    repeat (BIT) @(negedge clk);
    rb = 8'($urandom);
    send_frame(rb, 1'b1, -1);
    check_state("brk_rx");
    pop_check("brk");

    // random traffic with random reads
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, -1);
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) pop_check("rnd");
      end
    end
    while (exp_q.size() != 0) pop_check("rnd_drain");
    check_state("rnd_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
